// File: rtl/testvec_stream_framer_if.sv
// Stream bundle for the test-vector framer: free-running source side (s_*)
// and AXI-Stream master side (m_*). "master" is the framer's view.
interface testvec_stream_framer_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0]   s_tdata;
  logic                s_tvalid;
  logic [DATA_W-1:0]   m_tdata;
  logic [DATA_W/8-1:0] m_tkeep;
  logic                m_tlast;
  logic                m_tvalid;
  logic                m_tready;

  modport master (
    input  s_tdata, s_tvalid, m_tready,
    output m_tdata, m_tkeep, m_tlast, m_tvalid
  );

  modport slave (
    output s_tdata, s_tvalid, m_tready,
    input  m_tdata, m_tkeep, m_tlast, m_tvalid
  );
endinterface

// File: rtl/testvec_stream_framer.sv
// Buffers a valid-only test-vector stream in a small FIFO and cuts it into
// fixed-length AXI-Stream packets; beats arriving on a full FIFO are dropped.
module testvec_stream_framer #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_enable,
  input  logic [LEN_W-1:0]        cfg_pkt_len,
  testvec_stream_framer_if.master bus,
  output logic [31:0]             stat_pkt_cnt,
  output logic [31:0]             stat_drop_cnt,
  output logic                    stat_overflow,
  output logic                    busy
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_t            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [LEN_W-1:0]  r_beat, w_beat_nxt;
  logic              w_beat_last;
  logic              w_wr, w_wr_real, w_drop, w_rd;
  logic              w_full, w_empty;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_real [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];
  logic              w_m_last;
  logic [31:0]       r_pkt_cnt, r_drop_cnt;
  logic              r_overflow;

  // Reset asserts asynchronously, releases on the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_rd        = !w_empty && bus.m_tready;
  assign w_beat_last = (r_beat == r_len - LEN_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_beat_nxt  = r_beat;
    w_wr        = 1'b0;
    w_wr_real   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_enable) begin
          w_len_nxt   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
          w_beat_nxt  = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.s_tvalid) begin
          if (w_full) begin
            w_drop = 1'b1;
          end else begin
            w_wr       = 1'b1;
            w_wr_real  = 1'b1;
            w_beat_nxt = w_beat_last ? '0 : r_beat + LEN_W'(1);
          end
        end
        // Decide on the post-write count so a beat accepted as cfg_enable
        // falls can itself close the packet.
        if (!cfg_enable) w_state_nxt = (w_beat_nxt == '0) ? IDLE : PAD;
      end
      PAD: begin
        if (!w_full) begin
          w_wr       = 1'b1;
          w_beat_nxt = w_beat_last ? '0 : r_beat + LEN_W'(1);
          if (w_beat_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_len   <= LEN_W'(1);
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Storage is not reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_data[r_wr_ptr] <= w_wr_real ? bus.s_tdata : '0;
      r_mem_real[r_wr_ptr] <= w_wr_real;
      r_mem_last[r_wr_ptr] <= w_beat_last;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_rd) r_count <= r_count - CW'(1);
    end
  end

  assign w_m_last     = !w_empty && r_mem_last[r_rd_ptr];
  assign bus.m_tvalid = !w_empty;
  assign bus.m_tdata  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign bus.m_tkeep  = (!w_empty && r_mem_real[r_rd_ptr]) ? {KEEP_W{1'b1}} : '0;
  assign bus.m_tlast  = w_m_last;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_rd && w_m_last)               r_pkt_cnt  <= r_pkt_cnt + 32'd1;
      if (w_drop && (r_drop_cnt != '1))   r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_drop)                         r_overflow <= 1'b1;
    end
  end

  assign stat_pkt_cnt  = r_pkt_cnt;
  assign stat_drop_cnt = r_drop_cnt;
  assign stat_overflow = r_overflow;
  assign busy          = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_testvec_stream_framer.sv
// Scoreboard bench for testvec_stream_framer: a queue models FIFO contents and
// framing, and every output beat is compared against its head.
module tb_testvec_stream_framer;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int LW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_enable;
  logic [LW-1:0] cfg_pkt_len;
  logic [31:0]   stat_pkt_cnt, stat_drop_cnt;
  logic          stat_overflow, busy;

  testvec_stream_framer_if #(.DATA_W(DW)) bus ();

  testvec_stream_framer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_enable   (cfg_enable),
    .cfg_pkt_len  (cfg_pkt_len),
    .bus          (bus),
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_drop_cnt(stat_drop_cnt),
    .stat_overflow(stat_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] k;
    logic            l;
  } beat_t;

  beat_t       q[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          ms;        // model state: 0 idle, 1 run, 2 pad
  int          mlen;
  int          mbeat;
  logic [31:0] dcnt = 32'd0;
  logic [LW-1:0] cfg_len = '0;
  int          out_cnt;
  logic [63:0] out_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    ms    = 0;
    mbeat = 0;
    mlen  = 1;
  endtask

  task automatic rec_start();
    out_cnt  = 0;
    out_mask = '0;
  endtask

  // One clock: check DUT head against model, drive inputs, advance model.
  task automatic cycle(input logic en, input logic vld, input logic rdy);
    bit    full;
    bit    rd;
    beat_t b;
    @(negedge clk);
    chk("tvalid", 64'(bus.m_tvalid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("tdata", bus.m_tdata, q[0].d);
      chk("tkeep", 64'(bus.m_tkeep), 64'(q[0].k));
      chk("tlast", 64'(bus.m_tlast), 64'(q[0].l));
    end
    cfg_enable   = en;
    cfg_pkt_len  = cfg_len;
    bus.s_tvalid = vld;
    bus.s_tdata  = {32'hC0DE_0000, dcnt};
    bus.m_tready = rdy;
    full = (q.size() == DEPTH);
    rd   = (q.size() != 0) && rdy;
    if (rd) begin
      if (out_cnt < 64) out_mask[out_cnt] = q[0].l;
      out_cnt++;
      void'(q.pop_front());
    end
    case (ms)
      0: if (en) begin
        mlen  = (cfg_len == '0) ? 1 : int'(cfg_len);
        mbeat = 0;
        ms    = 1;
      end
      1: begin
        if (vld && !full) begin
          b.d = {32'hC0DE_0000, dcnt};
          b.k = '1;
          b.l = (mbeat == mlen - 1);
          q.push_back(b);
          mbeat = b.l ? 0 : mbeat + 1;
        end
        if (!en) ms = (mbeat == 0) ? 0 : 2;
      end
      default: if (!full) begin
        b.d = '0;
        b.k = '0;
        b.l = (mbeat == mlen - 1);
        q.push_back(b);
        mbeat = b.l ? 0 : mbeat + 1;
        if (b.l) ms = 0;
      end
    endcase
    if (vld) dcnt++;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      if (ms == 0 && q.size() == 0) begin
        done = 1;
        break;
      end
      cycle(1'b0, 1'b0, 1'b1);
    end
    if (!done) chk("drain_timeout", 64'(1), 64'(0));
    cycle(1'b0, 1'b0, 1'b1);
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    cfg_enable   = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b1;
    cfg_enable   = 1'b0;
    cfg_pkt_len  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.m_tready = 1'b0;
    model_clear();
    rec_start();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tvalid", 64'(bus.m_tvalid), 64'(0));
    chk("rst_tdata", bus.m_tdata, 64'(0));
    chk("rst_tlast", 64'(bus.m_tlast), 64'(0));
    chk("rst_pkt", 64'(stat_pkt_cnt), 64'(0));
    chk("rst_drop", 64'(stat_drop_cnt), 64'(0));
    chk("rst_ovf", 64'(stat_overflow), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // len=4, 10 beats, then disable: two pad beats close the third packet
    cfg_len = 16'd4;
    rec_start();
    cycle(1'b1, 1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b1, 1'b1);
    drain(100);
    chk("t1_beats", 64'(out_cnt), 64'(12));
    chk("t1_lastmask", out_mask, 64'h888);
    chk("t1_pkt", 64'(stat_pkt_cnt), 64'(3));
    chk("t1_drop", 64'(stat_drop_cnt), 64'(0));

    // len=0 behaves as len=1, with random backpressure
    do_reset();
    cfg_len = 16'd0;
    rec_start();
    cycle(1'b1, 1'b0, 1'b1);
    repeat (6) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    drain(100);
    chk("t3_beats", 64'(out_cnt), 64'(6));
    chk("t3_lastmask", out_mask, 64'h3F);
    chk("t3_pkt", 64'(stat_pkt_cnt), 64'(6));

    // disable right after the 8th beat with len=4: no padding
    do_reset();
    cfg_len = 16'd4;
    rec_start();
    cycle(1'b1, 1'b0, 1'b1);
    repeat (8) cycle(1'b1, 1'b1, 1'b1);
    drain(100);
    chk("t4_beats", 64'(out_cnt), 64'(8));
    chk("t4_lastmask", out_mask, 64'h88);
    chk("t4_pkt", 64'(stat_pkt_cnt), 64'(2));

    // length change mid-RUN takes effect only at the next enable
    do_reset();
    cfg_len = 16'd4;
    rec_start();
    cycle(1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    cfg_len = 16'd7;
    repeat (6) cycle(1'b1, 1'b1, 1'b1);
    drain(100);
    chk("t5a_beats", 64'(out_cnt), 64'(8));
    chk("t5a_lastmask", out_mask, 64'h88);
    rec_start();
    cycle(1'b1, 1'b0, 1'b1);
    repeat (7) cycle(1'b1, 1'b1, 1'b1);
    drain(100);
    chk("t5b_beats", 64'(out_cnt), 64'(7));
    chk("t5b_lastmask", out_mask, 64'h40);
    chk("t5_pkt", 64'(stat_pkt_cnt), 64'(3));

    // overflow: len=64, no ready for 20 input cycles
    do_reset();
    cfg_len = 16'd64;
    rec_start();
    cycle(1'b1, 1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("t2_drop_at_fill", 64'(stat_drop_cnt), 64'(4));
    chk("t2_ovf", 64'(stat_overflow), 64'(1));
    repeat (8) cycle(1'b1, 1'b1, 1'b1);
    drain(300);
    chk("t2_beats", 64'(out_cnt), 64'(64));
    chk("t2_lastmask", out_mask, 64'h8000_0000_0000_0000);
    chk("t2_pkt", 64'(stat_pkt_cnt), 64'(1));
    chk("t2_drop", 64'(stat_drop_cnt), 64'(4));

    // async reset with 5 beats queued mid-packet
    cfg_len = 16'd8;
    rec_start();
    cycle(1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tvalid", 64'(bus.m_tvalid), 64'(0));
    chk("t6_tdata", bus.m_tdata, 64'(0));
    chk("t6_tkeep", 64'(bus.m_tkeep), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_pkt", 64'(stat_pkt_cnt), 64'(0));
    chk("t6_drop", 64'(stat_drop_cnt), 64'(0));
    chk("t6_ovf", 64'(stat_overflow), 64'(0));
    model_clear();
    cfg_enable   = 1'b0;
    bus.s_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    cfg_len = 16'd2;
    rec_start();
    cycle(1'b1, 1'b0, 1'b1);
    repeat (4) cycle(1'b1, 1'b1, 1'b1);
    drain(100);
    chk("t6_post_beats", 64'(out_cnt), 64'(4));
    chk("t6_post_pkt", 64'(stat_pkt_cnt), 64'(2));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
